dense_stage_fp: RTL
===================

Name: dense_stage_fp

Overview:
Parametrised fixed-point dense (fully connected) stage for the classifier tail of the CNN pipeline. It accepts one flattened feature vector and serialises it internally into IN_PER_CYC-wide chunks. It drives the weight-ROM chunk address itself, accumulates per output channel, then adds bias, shifts, saturates and optionally applies ReLU. It replaces the hand-built to_serial, external chunk counter and dense_layer_fp chain with one handshaked unit.

Parameters:
BW, 16, signed data/bias/output width
BW_W, 8, signed weight width
IN_CH, 64, input vector length; must be a multiple of IN_PER_CYC (elaboration error otherwise)
IN_PER_CYC, 8, inputs consumed per accumulate cycle
OUT_CH, 16, output channels
R_SHIFT, 8, arithmetic right shift applied after accumulation
NUM_CYC, IN_CH/IN_PER_CYC, derived localparam; chunks per vector
ACC_BW, BW+BW_W+$clog2(IN_CH)+1, derived localparam; accumulator width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
vld_in  in  1  input vector valid
rdy_in  out  1  block can accept vld_in this cycle
data_in  in  IN_CH*BW  flattened signed input vector, element 0 in LSBs
bias  in  OUT_CH*BW  signed per-channel bias, static during operation
w_addr  out  max(1,$clog2(NUM_CYC))  weight-ROM chunk index
w_vec  in  IN_PER_CYC*OUT_CH*BW_W  weights for chunk w_addr, combinational ROM read, same cycle
vld_out  out  1  one-cycle result pulse
data_out  out  OUT_CH*BW  signed result, held until the next result
drop_err  out  1  sticky flag: vld_in seen while rdy_in low

Behaviour:
- Reset (rst=0, asynchronous): state IDLE, rdy_in=1, w_addr=0, vld_out=0, data_out=0, drop_err=0, accumulators 0.
- States: IDLE, ACC, OUT. rdy_in=1 in IDLE and OUT, 0 in ACC.
- Accept (vld_in & rdy_in): latch data_in into the shift register; load each accumulator with its sign-extended bias; chunk counter to 0; go to ACC.
- ACC, one cycle per chunk: w_addr = chunk index. acc[o] += sum over k of data[c*IN_PER_CYC+k] * w_vec[k][o], signed, full precision. Shift register advances one chunk. After chunk NUM_CYC-1, go to OUT.
- Weight layout: w_vec element (k,o) sits at bit offset (k*OUT_CH+o)*BW_W.
- OUT, one cycle: data_out[o] = sat_BW(acc[o] >>> R_SHIFT). The shift is arithmetic and truncates toward minus infinity; saturation limits are -2^(BW-1) and 2^(BW-1)-1. vld_out=1 this cycle only.
- OUT exit: with vld_in, accept and go to ACC; otherwise go to IDLE.
- Latency: vld_out is asserted NUM_CYC+1 cycles after the accept edge. Sustained throughput is one vector per NUM_CYC+1 cycles.
- w_addr is 0 whenever not in ACC. NUM_CYC=1 is legal: ACC lasts a single cycle.
- vld_in with rdy_in=0: input ignored, drop_err set, computation unaffected. drop_err clears only on reset.
- Reset mid-ACC: the operation is abandoned, no vld_out is produced, and the block returns to the reset state.

Optional Feature:
DENSE_STAGE_RELU_EN
- Defined: negative saturated results are clamped to 0 before registering data_out (fused ReLU).
- Undefined: signed saturated values pass through unchanged.

Decomposition:
- Shared package dense_pkg: functions for NUM_CYC/ACC_BW derivation, a signed saturate function sat_bw, and the state enum (IDLE, ACC, OUT).
- One sub-module, dense_mac_chunk: combinational IN_PER_CYC-term signed dot product for one output channel, instantiated OUT_CH times.

Test Plan:
Bench parameters: BW=16, BW_W=8, IN_CH=4, IN_PER_CYC=2, OUT_CH=2, R_SHIFT=2.
1. Reset: hold rst=0 -> all outputs 0, rdy_in=1; releasing rst with no vld_in -> outputs unchanged.
2. Basic: data=[1,2,3,4], all weights 1, bias 0, vld_in at cycle 0 -> w_addr 0 then 1 on cycles 1-2, vld_out at cycle 3, both channels=2 (10>>>2). Weights all -1 -> -3 (truncation toward minus infinity), or 0 with DENSE_STAGE_RELU_EN.
3. Saturation: data all 32767, weights 127, bias 32767 -> 32767. Data all -32768, weights 127 -> -32768 (0 with ReLU).
4. Busy drop: second vld_in at cycle 1 -> ignored, drop_err=1 from cycle 2, exactly one vld_out, first result unchanged.
5. Back-to-back: vld_in at cycles 0 and 3 (accepted in OUT) -> vld_out at cycles 3 and 6 with correct independent results; no drop_err.
6. Reset mid-op: rst=0 during cycle 1 -> no vld_out, w_addr=0 immediately, rdy_in=1. A following vector computes correctly.

Source files
------------

// File: rtl/dense_pkg.sv
// rtl/dense_pkg.sv - shared types and helpers for the dense stage
//   state_t    : controller states IDLE / ACC / OUT
//   num_cyc    : chunks per input vector
//   acc_bw     : accumulator width that cannot overflow for a full vector plus bias
//   sat_bw     : clamp a signed value to a signed bw-bit range (bw <= 64)
package dense_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      OUT  = 2'd2
   } state_t;

   function automatic int num_cyc(input int in_ch, input int in_per_cyc);
      return in_ch / in_per_cyc;
   endfunction

   function automatic int acc_bw(input int bw, input int bw_w, input int in_ch);
      return bw + bw_w + $clog2(in_ch) + 1;
   endfunction

   function automatic logic signed [63:0] sat_bw(input logic signed [63:0] v, input int bw);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (bw - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (bw - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/dense_mac_chunk.sv
// rtl/dense_mac_chunk.sv - signed IN_PER_CYC-term dot product for one output channel
//   data_chunk : IN_PER_CYC signed BW-bit inputs, element 0 in LSBs
//   w_chunk    : IN_PER_CYC signed BW_W-bit weights for this channel, element 0 in LSBs
//   dot        : full-precision signed sum, sign-extended to ACC_BW
module dense_mac_chunk #(
   parameter int BW         = 16,
   parameter int BW_W       = 8,
   parameter int IN_PER_CYC = 8,
   parameter int ACC_BW     = 31
) (
   input  logic [IN_PER_CYC*BW-1:0]   data_chunk,
   input  logic [IN_PER_CYC*BW_W-1:0] w_chunk,
   output logic signed [ACC_BW-1:0]   dot
);

   logic signed [BW+BW_W-1:0] prod [IN_PER_CYC];

   for (genvar k = 0; k < IN_PER_CYC; k++) begin : g_prod
      // Both operands signed, result width BW+BW_W holds the exact product.
      assign prod[k] = $signed(data_chunk[k*BW +: BW]) * $signed(w_chunk[k*BW_W +: BW_W]);
   end

   always_comb begin
      dot = '0;
      for (int k = 0; k < IN_PER_CYC; k++) begin
         dot = dot + ACC_BW'(prod[k]);
      end
   end

endmodule

// File: rtl/dense_stage_fp.sv
// rtl/dense_stage_fp.sv - handshaked fixed-point dense layer with internal chunk serialiser
//   clk, rst   : clock, asynchronous active-low reset
//   vld_in     : input vector valid; rdy_in high when it can be accepted
//   data_in    : IN_CH signed BW-bit inputs, element 0 in LSBs
//   bias       : OUT_CH signed BW-bit biases, static during operation
//   w_addr     : weight-ROM chunk index, 0 outside accumulation
//   w_vec      : weights for chunk w_addr, element (k,o) at bit (k*OUT_CH+o)*BW_W
//   vld_out    : one-cycle result pulse; data_out holds until the next result
//   drop_err   : sticky, set by vld_in while rdy_in is low
//   Optional: define DENSE_STAGE_RELU_EN to clamp negative results to 0.
module dense_stage_fp
   import dense_pkg::*;
#(
   parameter int BW         = 16,
   parameter int BW_W       = 8,
   parameter int IN_CH      = 64,
   parameter int IN_PER_CYC = 8,
   parameter int OUT_CH     = 16,
   parameter int R_SHIFT    = 8,
   localparam int NUM_CYC   = num_cyc(IN_CH, IN_PER_CYC),
   localparam int ACC_BW    = acc_bw(BW, BW_W, IN_CH),
   localparam int AW        = (NUM_CYC > 1) ? $clog2(NUM_CYC) : 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              vld_in,
   output logic                              rdy_in,
   input  logic [IN_CH*BW-1:0]               data_in,
   input  logic [OUT_CH*BW-1:0]              bias,
   output logic [AW-1:0]                     w_addr,
   input  logic [IN_PER_CYC*OUT_CH*BW_W-1:0] w_vec,
   output logic                              vld_out,
   output logic [OUT_CH*BW-1:0]              data_out,
   output logic                              drop_err
);

   localparam int CHUNK_W = IN_PER_CYC * BW;

   if (IN_CH % IN_PER_CYC != 0) begin : g_bad_cfg
      $error("dense_stage_fp: IN_CH must be a multiple of IN_PER_CYC");
   end

   state_t                    state_q, state_d;
   logic [IN_CH*BW-1:0]       sr_q, sr_d;
   logic [AW-1:0]             cnt_q, cnt_d;
   logic signed [ACC_BW-1:0]  acc_q [OUT_CH];
   logic signed [ACC_BW-1:0]  acc_d [OUT_CH];
   logic signed [ACC_BW-1:0]  acc_nxt [OUT_CH];
   logic                      vld_out_q, vld_out_d;
   logic [OUT_CH*BW-1:0]      dout_q, dout_d;
   logic                      drop_q, drop_d;
   logic [OUT_CH*BW-1:0]      res;
   logic                      accept;

   for (genvar o = 0; o < OUT_CH; o++) begin : g_ch
      logic [IN_PER_CYC*BW_W-1:0] w_ch;
      logic signed [ACC_BW-1:0]   dot;
      logic signed [ACC_BW-1:0]   shifted;
      logic signed [BW-1:0]       sat;

      // Gather this channel's weights out of the interleaved ROM word.
      for (genvar k = 0; k < IN_PER_CYC; k++) begin : g_w
         assign w_ch[k*BW_W +: BW_W] = w_vec[(k*OUT_CH+o)*BW_W +: BW_W];
      end

      // The lowest chunk of the shift register is always the current chunk.
      dense_mac_chunk #(
         .BW         (BW),
         .BW_W       (BW_W),
         .IN_PER_CYC (IN_PER_CYC),
         .ACC_BW     (ACC_BW)
      ) u_mac (
         .data_chunk (sr_q[CHUNK_W-1:0]),
         .w_chunk    (w_ch),
         .dot        (dot)
      );

      assign acc_nxt[o] = acc_q[o] + dot;
      // Arithmetic shift floors toward minus infinity.
      assign shifted    = acc_nxt[o] >>> R_SHIFT;
      assign sat        = BW'(sat_bw(64'(shifted), BW));
`ifdef DENSE_STAGE_RELU_EN
      assign res[o*BW +: BW] = sat[BW-1] ? '0 : sat;
`else
      assign res[o*BW +: BW] = sat;
`endif
   end

   assign rdy_in = (state_q != ACC);
   assign accept = vld_in & rdy_in;

   always_comb begin
      state_d   = state_q;
      sr_d      = sr_q;
      cnt_d     = cnt_q;
      acc_d     = acc_q;
      vld_out_d = 1'b0;
      dout_d    = dout_q;
      drop_d    = drop_q | (vld_in & ~rdy_in);
      case (state_q)
         IDLE, OUT: begin
            if (accept) begin
               state_d = ACC;
               sr_d    = data_in;
               cnt_d   = '0;
               for (int o = 0; o < OUT_CH; o++) begin
                  acc_d[o] = ACC_BW'($signed(bias[o*BW +: BW]));
               end
            end else begin
               state_d = IDLE;
            end
         end
         ACC: begin
            sr_d = sr_q >> CHUNK_W;
            for (int o = 0; o < OUT_CH; o++) begin
               acc_d[o] = acc_nxt[o];
            end
            // Result is registered on the last chunk so it is visible in OUT.
            if (cnt_q == AW'(NUM_CYC - 1)) begin
               state_d   = OUT;
               cnt_d     = '0;
               vld_out_d = 1'b1;
               dout_d    = res;
            end else begin
               cnt_d = cnt_q + AW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         sr_q      <= '0;
         cnt_q     <= '0;
         vld_out_q <= 1'b0;
         dout_q    <= '0;
         drop_q    <= 1'b0;
         for (int o = 0; o < OUT_CH; o++) begin
            acc_q[o] <= '0;
         end
      end else begin
         state_q   <= state_d;
         sr_q      <= sr_d;
         cnt_q     <= cnt_d;
         vld_out_q <= vld_out_d;
         dout_q    <= dout_d;
         drop_q    <= drop_d;
         for (int o = 0; o < OUT_CH; o++) begin
            acc_q[o] <= acc_d[o];
         end
      end
   end

   assign w_addr   = (state_q == ACC) ? cnt_q : '0;
   assign vld_out  = vld_out_q;
   assign data_out = dout_q;
   assign drop_err = drop_q;

endmodule
